// File: rtl/egr_dpb_batcher.sv
// egr_dpb_batcher
//   Collects dirty segment pointers from the PFS into an in-order FIFO and
//   hands them to the free-pointer manager in batches of up to BATCH lanes.
//   A batch leaves when BATCH pointers are waiting, when the oldest partial
//   batch has waited long enough (TMO), or when flush is raised.
//
// Ports
//   cclk            block clock, rising edge
//   rst_n           asynchronous active-low reset
//   pfs_dptr_valid  dirty pointer offered by the PFS
//   pfs_dptr        dirty pointer value
//   pfs_dptr_ready  pointer accepted this cycle (FIFO not full)
//   flush           push out a partial batch
//   free_valid      batch presented to the free-pointer manager
//   free_ptr        batch pointers, lane 0 in the low PTR_W bits
//   free_mask       lane-valid bits, contiguous from lane 0
//   free_ready      free-pointer manager accepts the batch
//   occupancy       registered FIFO entry count
//   idle            FIFO empty, no batch pending, FSM idle
//
// state   | meaning
// S_IDLE  | FIFO empty, nothing to send
// S_ACCUM | FIFO holds pointers, waiting for full batch / timeout / flush
// S_SEND  | output register holds a batch, waiting for free_ready

module egr_dpb_batcher #(
    parameter int PTR_W = 20,
    parameter int DEPTH = 16,
    parameter int BATCH = 4,
    parameter int TMO   = 32
) (
    input  logic                   cclk,
    input  logic                   rst_n,
    input  logic                   pfs_dptr_valid,
    input  logic [PTR_W-1:0]       pfs_dptr,
    output logic                   pfs_dptr_ready,
    input  logic                   flush,
    output logic                   free_valid,
    output logic [BATCH*PTR_W-1:0] free_ptr,
    output logic [BATCH-1:0]       free_mask,
    input  logic                   free_ready,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] BATCH_C  = CW'(BATCH);
    localparam logic [7:0]    TMO_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SEND} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [PTR_W-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          occ;
    logic [CW-1:0]          n_pop;
    logic [CW-1:0]          occ_nxt;
    logic [7:0]             timer;
    logic                   run;
    logic                   push;
    logic                   load;
    logic [BATCH*PTR_W-1:0] load_ptr;
    logic [BATCH-1:0]       load_mask;

    assign push    = pfs_dptr_valid && pfs_dptr_ready;
    assign load    = (state == S_ACCUM) && ((occ >= BATCH_C) || (timer == TMO_LAST) || flush);
    assign n_pop   = (occ >= BATCH_C) ? BATCH_C : occ;
    assign occ_nxt = occ + CW'(push) - (load ? n_pop : '0);

    // Gather the oldest n_pop entries; read index wraps naturally in AW bits.
    always_comb begin
        load_ptr  = '0;
        load_mask = '0;
        for (int i = 0; i < BATCH; i++) begin
            if (CW'(i) < n_pop) begin
                load_ptr[i*PTR_W +: PTR_W] = mem[rd_ptr + AW'(i)];
                load_mask[i]               = 1'b1;
            end
        end
    end

    always_ff @(posedge cclk) begin
        if (push) begin
            mem[wr_ptr] <= pfs_dptr;
        end
    end

    // run keeps ready low during reset and raises it on the first edge after.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            timer     <= '0;
            free_ptr  <= '0;
            free_mask <= '0;
        end else begin
            run <= 1'b1;
            occ <= occ_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr    <= rd_ptr + n_pop[AW-1:0];
                free_ptr  <= load_ptr;
                free_mask <= load_mask;
            end
            if (load || (occ == '0)) begin
                timer <= '0;
            end else if ((state == S_ACCUM) && (occ < BATCH_C)) begin
                timer <= timer + 8'd1;
            end
        end
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (occ != '0) state_nxt = S_ACCUM;
            S_ACCUM: if (load) state_nxt = S_SEND;
            S_SEND:  if (free_ready) state_nxt = (occ != '0) ? S_ACCUM : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        free_valid     = (state == S_SEND);
        idle           = (state == S_IDLE) && (occ == '0);
        pfs_dptr_ready = run && (occ < DEPTH_C);
        occupancy      = occ;
    end

endmodule

// File: tb/tb_egr_dpb_batcher.sv
module tb_egr_dpb_batcher;
    localparam int PTR_W = 20;
    localparam int DEPTH = 16;
    localparam int BATCH = 4;
    localparam int TMO   = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                   cclk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   pfs_dptr_valid = 1'b0;
    logic [PTR_W-1:0]       pfs_dptr = '0;
    logic                   pfs_dptr_ready;
    logic                   flush = 1'b0;
    logic                   free_valid;
    logic [BATCH*PTR_W-1:0] free_ptr;
    logic [BATCH-1:0]       free_mask;
    logic                   free_ready = 1'b0;
    logic [CW-1:0]          occupancy;
    logic                   idle;

    int n_cmp = 0;
    int n_err = 0;

    egr_dpb_batcher #(.PTR_W(PTR_W), .DEPTH(DEPTH), .BATCH(BATCH), .TMO(TMO)) dut (
        .cclk(cclk), .rst_n(rst_n),
        .pfs_dptr_valid(pfs_dptr_valid), .pfs_dptr(pfs_dptr), .pfs_dptr_ready(pfs_dptr_ready),
        .flush(flush),
        .free_valid(free_valid), .free_ptr(free_ptr), .free_mask(free_mask), .free_ready(free_ready),
        .occupancy(occupancy), .idle(idle)
    );

    always #5 cclk = ~cclk;

    function automatic logic [PTR_W-1:0] lane_of(input int i);
        return free_ptr[i*PTR_W +: PTR_W];
    endfunction

    task automatic quiet_inputs();
        pfs_dptr_valid = 1'b0;
        pfs_dptr       = '0;
        flush          = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        quiet_inputs();
        free_ready = 1'b0;
        repeat (3) @(negedge cclk);
        n_cmp++; if (free_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", free_valid); end
        n_cmp++; if (occupancy !== '0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_cmp++; if (pfs_dptr_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", pfs_dptr_ready); end
        n_cmp++; if (free_mask !== '0) begin n_err++; $display("FAIL reset_mask: got %h want 0", free_mask); end
        n_cmp++; if (free_ptr !== '0) begin n_err++; $display("FAIL reset_ptr: got %h want 0", free_ptr); end
        rst_n = 1'b1;
        @(negedge cclk);
        n_cmp++; if (pfs_dptr_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", pfs_dptr_ready); end
    endtask

    // Four back-to-back pointers form one full batch on the edge after the fourth.
    task automatic test_full_batch();
        free_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pfs_dptr_valid = 1'b1;
            pfs_dptr       = PTR_W'(32'h10 + i);
            @(negedge cclk);
            if (i == 0) begin
                n_cmp++; if (occupancy !== CW'(1)) begin n_err++; $display("FAIL full_occ_latency: got %0d want 1", occupancy); end
            end
        end
        quiet_inputs();
        n_cmp++; if (free_valid !== 1'b0) begin n_err++; $display("FAIL full_early_valid: got %b want 0", free_valid); end
        n_cmp++; if (occupancy !== CW'(4)) begin n_err++; $display("FAIL full_occ4: got %0d want 4", occupancy); end
        @(negedge cclk);
        n_cmp++; if (free_valid !== 1'b1) begin n_err++; $display("FAIL full_valid: got %b want 1", free_valid); end
        n_cmp++; if (free_mask !== 4'b1111) begin n_err++; $display("FAIL full_mask: got %b want 1111", free_mask); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (lane_of(i) !== PTR_W'(32'h10 + i)) begin
                n_err++; $display("FAIL full_lane%0d: got %h want %h", i, lane_of(i), 32'h10 + i);
            end
        end
        n_cmp++; if (occupancy !== '0) begin n_err++; $display("FAIL full_occ_after: got %0d want 0", occupancy); end
        @(negedge cclk);
        n_cmp++; if (free_valid !== 1'b0) begin n_err++; $display("FAIL full_valid_drop: got %b want 0", free_valid); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL full_idle: got %b want 1", idle); end
    endtask

    // One lonely pointer: free_valid rises on the TMO+1-th edge after the accepting edge.
    task automatic test_timeout();
        int                     seen;
        logic [BATCH-1:0]       s_mask;
        logic [BATCH*PTR_W-1:0] s_ptr;
        logic [BATCH*PTR_W-1:0] e_ptr;
        seen   = 0;
        s_mask = '0;
        s_ptr  = '0;
        free_ready     = 1'b1;
        pfs_dptr_valid = 1'b1;
        pfs_dptr       = PTR_W'(32'h55);
        @(negedge cclk);
        quiet_inputs();
        for (int k = 1; k <= TMO + 10; k++) begin
            @(negedge cclk);
            if (free_valid && seen == 0) begin
                seen   = k;
                s_mask = free_mask;
                s_ptr  = free_ptr;
            end
        end
        e_ptr = '0;
        e_ptr[PTR_W-1:0] = PTR_W'(32'h55);
        n_cmp++; if (seen != TMO + 1) begin n_err++; $display("FAIL tmo_latency: got %0d want %0d", seen, TMO + 1); end
        n_cmp++; if (s_mask !== 4'b0001) begin n_err++; $display("FAIL tmo_mask: got %b want 0001", s_mask); end
        n_cmp++; if (s_ptr !== e_ptr) begin n_err++; $display("FAIL tmo_ptr: got %h want %h", s_ptr, e_ptr); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL tmo_idle: got %b want 1", idle); end
    endtask

    task automatic test_flush();
        free_ready = 1'b1;
        flush      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge cclk);
            n_cmp++; if (free_valid !== 1'b0 || idle !== 1'b1) begin
                n_err++; $display("FAIL flush_empty: got valid=%b idle=%b want valid=0 idle=1", free_valid, idle);
            end
        end
        flush = 1'b0;
        pfs_dptr_valid = 1'b1;
        pfs_dptr       = PTR_W'(32'hA1);
        @(negedge cclk);
        pfs_dptr       = PTR_W'(32'hA2);
        @(negedge cclk);
        pfs_dptr_valid = 1'b0;
        flush          = 1'b1;
        @(negedge cclk);
        flush = 1'b0;
        n_cmp++; if (free_valid !== 1'b1) begin n_err++; $display("FAIL flush_valid: got %b want 1", free_valid); end
        n_cmp++; if (free_mask !== 4'b0011) begin n_err++; $display("FAIL flush_mask: got %b want 0011", free_mask); end
        n_cmp++; if (lane_of(0) !== PTR_W'(32'hA1) || lane_of(1) !== PTR_W'(32'hA2)) begin
            n_err++; $display("FAIL flush_lanes01: got %h %h want a1 a2", lane_of(0), lane_of(1));
        end
        n_cmp++; if (lane_of(2) !== '0 || lane_of(3) !== '0) begin
            n_err++; $display("FAIL flush_unused: got %h %h want 0 0", lane_of(2), lane_of(3));
        end
        @(negedge cclk);
        n_cmp++; if (free_valid !== 1'b0 || idle !== 1'b1) begin
            n_err++; $display("FAIL flush_done: got valid=%b idle=%b want 0 1", free_valid, idle);
        end
    endtask

    task automatic test_backpressure();
        int                     accepted;
        int                     batches;
        logic [PTR_W-1:0]       nxt;
        logic [BATCH*PTR_W-1:0] e_ptr;
        accepted   = 0;
        free_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pfs_dptr_valid = 1'b1;
            pfs_dptr       = PTR_W'(32'h100 + i);
            if (pfs_dptr_ready) accepted++;
            @(negedge cclk);
        end
        n_cmp++; if (accepted != 20) begin n_err++; $display("FAIL bp_accept: got %0d want 20", accepted); end
        for (int i = 0; i < BATCH; i++) e_ptr[i*PTR_W +: PTR_W] = PTR_W'(32'h100 + i);
        pfs_dptr = PTR_W'(32'h3FF);
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (pfs_dptr_ready !== 1'b0 || occupancy !== CW'(16)) begin
                n_err++; $display("FAIL bp_full: got ready=%b occ=%0d want 0 16", pfs_dptr_ready, occupancy);
            end
            n_cmp++; if (free_valid !== 1'b1 || free_mask !== 4'b1111 || free_ptr !== e_ptr) begin
                n_err++; $display("FAIL bp_hold: got v=%b m=%b p=%h want 1 1111 %h", free_valid, free_mask, free_ptr, e_ptr);
            end
            @(negedge cclk);
        end
        quiet_inputs();
        free_ready = 1'b1;
        batches    = 0;
        nxt        = PTR_W'(32'h100);
        for (int c = 0; c < 60; c++) begin
            if (free_valid) begin
                for (int i = 0; i < BATCH; i++) e_ptr[i*PTR_W +: PTR_W] = nxt + PTR_W'(i);
                n_cmp++; if (free_mask !== 4'b1111 || free_ptr !== e_ptr) begin
                    n_err++; $display("FAIL bp_batch%0d: got m=%b p=%h want 1111 %h", batches, free_mask, free_ptr, e_ptr);
                end
                batches++;
                nxt = nxt + PTR_W'(BATCH);
            end
            @(negedge cclk);
        end
        n_cmp++; if (batches != 5) begin n_err++; $display("FAIL bp_count: got %0d want 5", batches); end
        n_cmp++; if (occupancy !== '0 || idle !== 1'b1) begin
            n_err++; $display("FAIL bp_drain: got occ=%0d idle=%b want 0 1", occupancy, idle);
        end
    endtask

    // Random traffic against an ordered-queue reference: every batch must carry
    // min(waiting, BATCH) oldest pointers, and occupancy must equal the queue size.
    task automatic test_random();
        logic [PTR_W-1:0]       q[$];
        logic [PTR_W-1:0]       seq;
        logic [PTR_W-1:0]       p_val;
        logic                   p_push;
        logic                   pv;
        logic                   pready;
        logic [BATCH*PTR_W-1:0] s_ptr;
        logic [BATCH-1:0]       s_mask;
        logic [BATCH-1:0]       e_mask;
        logic [PTR_W-1:0]       e_lane;
        int                     n;
        int                     popped;
        seq    = PTR_W'(32'h1000);
        p_push = 1'b0;
        p_val  = '0;
        pv     = free_valid;
        pready = free_ready;
        s_ptr  = free_ptr;
        s_mask = free_mask;
        popped = 0;
        for (int c = 0; c < 650; c++) begin
            @(negedge cclk);
            if (free_valid && !pv) begin
                n = (q.size() < BATCH) ? q.size() : BATCH;
                e_mask = BATCH'((1 << n) - 1);
                n_cmp++; if (free_mask !== e_mask) begin
                    n_err++; $display("FAIL rnd_mask c=%0d: got %b want %b", c, free_mask, e_mask);
                end
                for (int i = 0; i < BATCH; i++) begin
                    e_lane = (i < n) ? q[i] : '0;
                    n_cmp++; if (lane_of(i) !== e_lane) begin
                        n_err++; $display("FAIL rnd_lane%0d c=%0d: got %h want %h", i, c, lane_of(i), e_lane);
                    end
                end
                for (int i = 0; i < n; i++) void'(q.pop_front());
                popped += n;
            end
            if (p_push) q.push_back(p_val);
            n_cmp++; if (int'(occupancy) != q.size()) begin
                n_err++; $display("FAIL rnd_occ c=%0d: got %0d want %0d", c, occupancy, q.size());
            end
            n_cmp++; if (pfs_dptr_ready !== (q.size() < DEPTH)) begin
                n_err++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, pfs_dptr_ready, q.size() < DEPTH);
            end
            if (pv && pready) begin
                n_cmp++; if (free_valid !== 1'b0) begin n_err++; $display("FAIL rnd_hs_drop c=%0d: got %b want 0", c, free_valid); end
            end else if (pv) begin
                n_cmp++; if (free_valid !== 1'b1 || free_ptr !== s_ptr || free_mask !== s_mask) begin
                    n_err++; $display("FAIL rnd_stable c=%0d: got v=%b m=%b p=%h want 1 %b %h", c, free_valid, free_mask, free_ptr, s_mask, s_ptr);
                end
            end
            if (c < 450) begin
                pfs_dptr_valid = ($urandom_range(0, 3) != 0);
                pfs_dptr       = seq;
                free_ready     = ($urandom_range(0, 2) == 0);
                flush          = ($urandom_range(0, 15) == 0);
            end else begin
                quiet_inputs();
                free_ready = 1'b1;
            end
            p_push = pfs_dptr_valid && (q.size() < DEPTH);
            p_val  = pfs_dptr;
            if (p_push) seq = seq + PTR_W'(1);
            pv     = free_valid;
            pready = free_ready;
            s_ptr  = free_ptr;
            s_mask = free_mask;
        end
        n_cmp++; if (q.size() != 0 || idle !== 1'b1) begin
            n_err++; $display("FAIL rnd_drain: got left=%0d idle=%b want 0 1", q.size(), idle);
        end
        n_cmp++; if (popped != int'(seq - PTR_W'(32'h1000))) begin
            n_err++; $display("FAIL rnd_total: got %0d popped want %0d", popped, seq - PTR_W'(32'h1000));
        end
    endtask

    task automatic test_reset_mid_send();
        int seen;
        free_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pfs_dptr_valid = 1'b1;
            pfs_dptr       = PTR_W'(32'h20 + i);
            @(negedge cclk);
        end
        quiet_inputs();
        for (int k = 0; k < 10 && !free_valid; k++) @(negedge cclk);
        n_cmp++; if (free_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b want 1", free_valid); end
        @(posedge cclk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (free_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b want 0", free_valid); end
        n_cmp++; if (occupancy !== '0 || idle !== 1'b1) begin
            n_err++; $display("FAIL rst_async_state: got occ=%0d idle=%b want 0 1", occupancy, idle);
        end
        n_cmp++; if (pfs_dptr_ready !== 1'b0 || free_mask !== '0) begin
            n_err++; $display("FAIL rst_async_out: got ready=%b mask=%b want 0 0", pfs_dptr_ready, free_mask);
        end
        @(negedge cclk);
        rst_n = 1'b1;
        @(negedge cclk);
        free_ready = 1'b1;
        n_cmp++; if (pfs_dptr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_back: got %b want 1", pfs_dptr_ready); end
        pfs_dptr_valid = 1'b1;
        pfs_dptr       = PTR_W'(32'h7);
        @(negedge cclk);
        quiet_inputs();
        seen = 0;
        for (int k = 1; k <= TMO + 10 && seen == 0; k++) begin
            @(negedge cclk);
            if (free_valid) seen = k;
        end
        n_cmp++; if (seen == 0) begin n_err++; $display("FAIL rst_post_batch: got none want a batch"); end
        n_cmp++; if (free_mask !== 4'b0001 || lane_of(0) !== PTR_W'(32'h7)) begin
            n_err++; $display("FAIL rst_post_lane0: got m=%b l0=%h want 0001 7", free_mask, lane_of(0));
        end
        @(negedge cclk);
    endtask

    initial begin
        test_reset();
        test_full_batch();
        test_timeout();
        test_flush();
        test_backpressure();
        test_random();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
